// File: rtl/types_pkg.sv
// Shared types for the 16-bit pipelined core: datapath words, memory control,
// and the memory/writeback stage bundle.
package types_pkg;

  localparam int unsigned XLEN = 16;
  localparam int unsigned DLEN = 32;

  typedef logic [XLEN-1:0] uword;

  typedef struct packed {
    logic mem2r;
    logic memwr;
  } memc_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } dmem_state_e;

  typedef struct packed {
    uword            instr;
    logic [DLEN-1:0] alu;
    logic [DLEN-1:0] data;
    logic            reg_wr;
    logic            mem2r;
    logic            R0_en;
  } wb_t;

endpackage

// File: rtl/watchdog_counter.sv
// Cycle counter that flags the last allowed cycle of an outstanding access.
module watchdog_counter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_cnt <= '0;
    else if (clr)  r_cnt <= '0;
    else if (en)   r_cnt <= r_cnt + CW'(1);
  end

  assign expired = en && (r_cnt == LAST);

endmodule

// File: rtl/stage_mem_wb.sv
// Memory/writeback stage: registers the execute result bundle, runs load/store
// accesses over a req/ack data-memory port, and stalls upstream while waiting.
module stage_mem_wb
  import types_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt_sys,
  input  memc_t       in_memc,
  input  logic        in_reg_wr,
  input  logic        in_R0_en,
  input  uword        in_instr,
  input  logic [31:0] in_alu,
  input  uword        in_R1_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_ack,
  output uword        s3_instruction,
  output logic [31:0] s3_alu,
  output logic [31:0] s3_data,
  output logic        s3_reg_wr,
  output logic        s3_mem2r,
  output logic        s3_R0_en,
  output logic        mem_busy,
  output logic        align_err,
  output logic        bus_err
);

  dmem_state_e r_state, w_state_nxt;
  wb_t         r_wb, w_wb_nxt;
  logic        r_req, w_req_nxt;
  logic        r_we, w_we_nxt;
  logic [15:0] r_addr, w_addr_nxt;
  logic [15:0] r_wdata, w_wdata_nxt;
  logic        r_align_err, w_align_nxt;
  logic        r_bus_err, w_bus_nxt;

  logic w_is_mem;
  logic w_expired;
  logic w_wd_clr;
  logic w_wd_en;

  assign w_is_mem = in_memc.mem2r | in_memc.memwr;

  // Counter runs only while waiting and restarts on every exit from WAIT.
  assign w_wd_en  = (r_state == WAIT);
  assign w_wd_clr = (r_state != WAIT) || (w_state_nxt != WAIT);

  watchdog_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_wd_clr),
    .en      (w_wd_en),
    .expired (w_expired)
  );

  // Next-state and next-register values; write enables default to a bubble.
  always_comb begin
    w_state_nxt     = r_state;
    w_wb_nxt        = r_wb;
    w_wb_nxt.reg_wr = 1'b0;
    w_wb_nxt.mem2r  = 1'b0;
    w_req_nxt       = r_req;
    w_we_nxt        = r_we;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_align_nxt     = r_align_err;
    w_bus_nxt       = r_bus_err;

    case (r_state)
      IDLE: begin
        if (!halt_sys) begin
          if (!w_is_mem) begin
            w_wb_nxt.instr  = in_instr;
            w_wb_nxt.alu    = in_alu;
            w_wb_nxt.data   = in_alu;
            w_wb_nxt.reg_wr = in_reg_wr;
            w_wb_nxt.R0_en  = in_R0_en;
          end else if (in_alu[0]) begin
            w_align_nxt = 1'b1;
          end else begin
            // Load wins when both memory controls are set.
            w_addr_nxt     = in_alu[15:0];
            w_wdata_nxt    = in_R1_data;
            w_we_nxt       = in_memc.memwr & ~in_memc.mem2r;
            w_req_nxt      = 1'b1;
            w_wb_nxt.instr = in_instr;
            w_wb_nxt.alu   = in_alu;
            w_wb_nxt.R0_en = in_R0_en;
            w_state_nxt    = WAIT;
          end
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = IDLE;
          if (!r_we) begin
            w_wb_nxt.data  = {16'd0, dmem_rdata};
            w_wb_nxt.mem2r = 1'b1;
            w_wb_nxt.R0_en = 1'b0;
          end
        end else if (w_expired) begin
          w_req_nxt   = 1'b0;
          w_bus_nxt   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_wb        <= '0;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_align_err <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wb        <= w_wb_nxt;
      r_req       <= w_req_nxt;
      r_we        <= w_we_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_align_err <= w_align_nxt;
      r_bus_err   <= w_bus_nxt;
    end
  end

  assign dmem_req       = r_req;
  assign dmem_we        = r_we;
  assign dmem_addr      = r_addr;
  assign dmem_wdata     = r_wdata;
  assign s3_instruction = r_wb.instr;
  assign s3_alu         = r_wb.alu;
  assign s3_data        = r_wb.data;
  assign s3_reg_wr      = r_wb.reg_wr;
  assign s3_mem2r       = r_wb.mem2r;
  assign s3_R0_en       = r_wb.R0_en;
  assign mem_busy       = (r_state == WAIT);
  assign align_err      = r_align_err;
  assign bus_err        = r_bus_err;

endmodule
